// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter in front of one shared memory port.
// Round-robin grant, one outstanding transaction, registered response pulse and
// a watchdog that completes a hung transaction with an error pattern.
module mem_arbiter #(
    parameter int unsigned AWIDTH         = 32,
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    // master 0: instruction fetch
    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [AWIDTH-1:0]   m0_addr,
    input  logic                m0_we,
    input  logic [DWIDTH-1:0]   m0_wdata,
    input  logic [DWIDTH/8-1:0] m0_wstrb,
    output logic                m0_resp_valid,
    output logic [DWIDTH-1:0]   m0_resp_rdata,
    // master 1: data
    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [AWIDTH-1:0]   m1_addr,
    input  logic                m1_we,
    input  logic [DWIDTH-1:0]   m1_wdata,
    input  logic [DWIDTH/8-1:0] m1_wstrb,
    output logic                m1_resp_valid,
    output logic [DWIDTH-1:0]   m1_resp_rdata,
    // shared memory
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [AWIDTH-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DWIDTH-1:0]   mem_wdata,
    output logic [DWIDTH/8-1:0] mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [DWIDTH-1:0]   mem_resp_rdata,
    // watchdog
    output logic                err_timeout,
    input  logic                err_clear
);

    localparam int unsigned SW   = DWIDTH / 8;
    // Counter only needs to reach TIMEOUT_CYCLES-1; the terminal count fires the timeout.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0]   CntLast     = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [DWIDTH-1:0] TimeoutData = DWIDTH'(32'hDEADBEEF);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic              gnt_id_q, gnt_id_d;
    logic              last_grant_q, last_grant_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rv0_q, rv0_d, rv1_q, rv1_d;
    logic [DWIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

    logic              can_grant, gnt0, gnt1, to_hit, finish, timeout;
    logic [DWIDTH-1:0] done_data;

    // Grant decode: no grant while a response pulse is on the wire; ties go to
    // the master that was not served last (last_grant_q = 1 means m1).
    always_comb begin
        can_grant = (state_q == StIdle) && !rv0_q && !rv1_q;
        gnt0      = can_grant && m0_req_valid && (!m1_req_valid || last_grant_q);
        gnt1      = can_grant && m1_req_valid && (!m0_req_valid || !last_grant_q);
        to_hit    = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);
    end

    // Next-state, latching, watchdog and response generation.
    always_comb begin
        state_d      = state_q;
        gnt_id_d     = gnt_id_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        cnt_d        = cnt_q;
        err_d        = err_q & ~err_clear;
        rv0_d        = 1'b0;
        rv1_d        = 1'b0;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        finish       = 1'b0;
        timeout      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
                    gnt_id_d = gnt1;
                    addr_d   = gnt1 ? m1_addr  : m0_addr;
                    we_d     = gnt1 ? m1_we    : m0_we;
                    wdata_d  = gnt1 ? m1_wdata : m0_wdata;
                    wstrb_d  = gnt1 ? m1_wstrb : m0_wstrb;
                    cnt_d    = '0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + CntW'(1);
                if (to_hit) begin
                    timeout = 1'b1;
                end else if (mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // A real response arriving on the terminal cycle still wins.
                if (mem_resp_valid) begin
                    finish = 1'b1;
                end else if (to_hit) begin
                    timeout = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        done_data = timeout ? TimeoutData : mem_resp_rdata;
        if (finish || timeout) begin
            state_d      = StIdle;
            last_grant_d = gnt_id_q;
            if (gnt_id_q) begin
                rv1_d = 1'b1;
                rd1_d = done_data;
            end else begin
                rv0_d = 1'b1;
                rd0_d = done_data;
            end
        end
        // Set beats a simultaneous clear.
        if (timeout) err_d = 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            gnt_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rv0_q        <= 1'b0;
            rv1_q        <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_id_q     <= gnt_id_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rv0_q        <= rv0_d;
            rv1_q        <= rv1_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    assign m0_req_ready  = gnt0;
    assign m1_req_ready  = gnt1;
    assign m0_resp_valid = rv0_q;
    assign m1_resp_valid = rv1_q;
    assign m0_resp_rdata = rd0_q;
    assign m1_resp_rdata = rd1_q;
    assign mem_req_valid = (state_q == StIssue);
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, stalled write, round-robin,
// watchdog with sticky error, and reset in the middle of a transaction.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req_valid, m0_req_ready, m0_we, m0_resp_valid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_resp_rdata;
    logic [3:0]    m0_wstrb;
    logic          m1_req_valid, m1_req_ready, m1_we, m1_resp_valid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_resp_rdata;
    logic [3:0]    m1_wstrb;
    logic          mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_resp_rdata;
    logic [3:0]    mem_wstrb;
    logic          err_timeout, err_clear;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(
        .AWIDTH         (AW),
        .DWIDTH         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_req_valid   (m0_req_valid),
        .m0_req_ready   (m0_req_ready),
        .m0_addr        (m0_addr),
        .m0_we          (m0_we),
        .m0_wdata       (m0_wdata),
        .m0_wstrb       (m0_wstrb),
        .m0_resp_valid  (m0_resp_valid),
        .m0_resp_rdata  (m0_resp_rdata),
        .m1_req_valid   (m1_req_valid),
        .m1_req_ready   (m1_req_ready),
        .m1_addr        (m1_addr),
        .m1_we          (m1_we),
        .m1_wdata       (m1_wdata),
        .m1_wstrb       (m1_wstrb),
        .m1_resp_valid  (m1_resp_valid),
        .m1_resp_rdata  (m1_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .err_timeout    (err_timeout),
        .err_clear      (err_clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req_valid = 0; m0_addr = '0; m0_we = 0; m0_wdata = '0; m0_wstrb = '0;
        m1_req_valid = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0; m1_wstrb = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0; err_clear = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_m0_resp", m0_resp_valid, 0);
        chk("rst_m1_resp", m1_resp_valid, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_m0_rdata", m0_resp_rdata, 0);
        rst_n = 1'b1;

        // m0 read of 0x100, immediate accept, response the following cycle
        m0_req_valid = 1; m0_addr = 32'h100; m0_we = 0; #1;
        chk("rd_m0_ready", m0_req_ready, 1);
        chk("rd_m1_ready", m1_req_ready, 0);
        chk("rd_idle_mem_valid", mem_req_valid, 0);
        tick();
        m0_req_valid = 0; m0_addr = '0; mem_req_ready = 1; #1;
        chk("rd_issue_valid", mem_req_valid, 1);
        chk("rd_issue_addr", mem_addr, 32'h100);
        chk("rd_issue_we", mem_we, 0);
        chk("rd_issue_m0_ready", m0_req_ready, 0);
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h12345678; #1;
        chk("rd_wait_mem_valid", mem_req_valid, 0);
        chk("rd_wait_no_pulse", m0_resp_valid, 0);
        tick();
        mem_resp_valid = 0; m1_req_valid = 1; #1;
        chk("rd_pulse", m0_resp_valid, 1);
        chk("rd_rdata", m0_resp_rdata, 32'h12345678);
        chk("rd_m1_no_pulse", m1_resp_valid, 0);
        chk("rd_no_grant_in_pulse", m1_req_ready, 0);
        // m1 withdraws before grant; a stray memory response arrives in IDLE
        m1_req_valid = 0; mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0; #1;
        chk("rd_pulse_one_cycle", m0_resp_valid, 0);
        chk("rd_rdata_hold", m0_resp_rdata, 32'h12345678);
        chk("drop_not_granted", mem_req_valid, 0);
        tick();
        chk("stray_resp_m0", m0_resp_valid, 0);
        chk("stray_resp_m1", m1_resp_valid, 0);
        chk("stray_idle", mem_req_valid, 0);

        // m1 write with memory stalling 5 cycles
        m1_req_valid = 1; m1_addr = 32'h200; m1_we = 1; m1_wdata = 32'hA5A5A5A5;
        m1_wstrb = 4'b0011; #1;
        chk("wr_m1_ready", m1_req_ready, 1);
        chk("wr_m0_ready", m0_req_ready, 0);
        tick();
        m1_req_valid = 0; m1_addr = 32'hFFF; m1_we = 0; m1_wdata = '0; m1_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wr_stall_valid", mem_req_valid, 1);
            chk("wr_stall_addr", mem_addr, 32'h200);
            chk("wr_stall_we", mem_we, 1);
            chk("wr_stall_wdata", mem_wdata, 32'hA5A5A5A5);
            chk("wr_stall_wstrb", mem_wstrb, 4'b0011);
            tick();
        end
        mem_req_ready = 1; #1;
        chk("wr_hs_valid", mem_req_valid, 1);
        chk("wr_hs_addr", mem_addr, 32'h200);
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFEF00D; #1;
        chk("wr_single_hs", mem_req_valid, 0);
        tick();
        mem_resp_valid = 0; #1;
        chk("wr_pulse", m1_resp_valid, 1);
        chk("wr_rdata", m1_resp_rdata, 32'hCAFEF00D);
        chk("wr_m0_quiet", m0_resp_valid, 0);
        chk("wr_m0_rdata_hold", m0_resp_rdata, 32'h12345678);
        tick();
        chk("wr_pulse_end", m1_resp_valid, 0);

        // Both masters requesting continuously: m1 was served last, so m0 first
        m0_addr = 32'h10; m0_we = 0; m1_addr = 32'h20; m1_we = 0;
        m0_req_valid = 1; m1_req_valid = 1; mem_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic e1;
            e1 = (i % 2) == 1;
            #1;
            chk("rr_m0_ready", m0_req_ready, !e1);
            chk("rr_m1_ready", m1_req_ready, e1);
            tick();
            chk("rr_addr", mem_addr, e1 ? 32'h20 : 32'h10);
            tick();
            mem_resp_valid = 1; mem_resp_rdata = i;
            tick();
            mem_resp_valid = 0; #1;
            chk("rr_m0_pulse", m0_resp_valid, !e1);
            chk("rr_m1_pulse", m1_resp_valid, e1);
            tick();
        end
        m0_req_valid = 0; m1_req_valid = 0; mem_req_ready = 0;

        // Watchdog: memory accepts but never responds
        m0_req_valid = 1; m0_addr = 32'h300; #1;
        chk("to_m0_ready", m0_req_ready, 1);
        tick();
        m0_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        repeat (6) tick();
        chk("to_not_yet_err", err_timeout, 0);
        chk("to_not_yet_pulse", m0_resp_valid, 0);
        tick();
        chk("to_err_set", err_timeout, 1);
        chk("to_pulse", m0_resp_valid, 1);
        chk("to_rdata", m0_resp_rdata, 32'hDEADBEEF);
        chk("to_m1_quiet", m1_resp_valid, 0);
        mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0; #1;
        chk("to_pulse_end", m0_resp_valid, 0);
        chk("to_sticky", err_timeout, 1);
        tick();
        chk("to_late_ignored", m0_resp_valid, 0);
        chk("to_sticky2", err_timeout, 1);
        err_clear = 1;
        tick();
        err_clear = 0; #1;
        chk("to_cleared", err_timeout, 0);

        // Second timeout with err_clear asserted on the same cycle: set wins
        m1_req_valid = 1; m1_addr = 32'h400; #1;
        chk("to2_m1_ready", m1_req_ready, 1);
        tick();
        m1_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        repeat (6) tick();
        err_clear = 1; #1;
        chk("to2_before", err_timeout, 0);
        tick();
        err_clear = 0; #1;
        chk("to2_set_wins", err_timeout, 1);
        chk("to2_pulse", m1_resp_valid, 1);
        chk("to2_rdata", m1_resp_rdata, 32'hDEADBEEF);
        tick();

        // Complete an m0 transaction so m1 would win the next tie without reset
        m0_req_valid = 1; m0_addr = 32'h500; #1;
        chk("pre_m0_ready", m0_req_ready, 1);
        tick();
        m0_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h55;
        tick();
        mem_resp_valid = 0; #1;
        chk("pre_pulse", m0_resp_valid, 1);
        chk("pre_rdata", m0_resp_rdata, 32'h55);
        tick();

        // Start another m0 transaction and reset it while in WAIT
        m0_req_valid = 1; #1;
        tick();
        m0_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; #1;
        chk("mid_wait", mem_req_valid, 0);
        rst_n = 1'b0; #1;
        chk("mid_rst_err", err_timeout, 0);
        chk("mid_rst_valid", mem_req_valid, 0);
        chk("mid_rst_m0_pulse", m0_resp_valid, 0);
        chk("mid_rst_m0_rdata", m0_resp_rdata, 0);
        chk("mid_rst_m1_rdata", m1_resp_rdata, 0);
        chk("mid_rst_addr", mem_addr, 0);
        tick();
        rst_n = 1'b1; mem_resp_valid = 1; mem_resp_rdata = 32'h77;
        tick();
        mem_resp_valid = 0; #1;
        chk("late_m0_pulse", m0_resp_valid, 0);
        chk("late_m1_pulse", m1_resp_valid, 0);
        chk("late_rdata", m0_resp_rdata, 0);
        m0_req_valid = 1; m1_req_valid = 1; #1;
        chk("post_rst_m0_wins", m0_req_ready, 1);
        chk("post_rst_m1_loses", m1_req_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
